// File: rtl/hazard_stall_unit_if.sv
// hazard_stall_unit_if: hazard inputs from the pipeline and stall/flush controls back to it
interface hazard_stall_unit_if #(parameter int CNT_W = 16);
    logic             idex_mem_read;
    logic             idex_reg_write;
    logic [4:0]       idex_rd;
    logic             exmem_mem_read;
    logic [4:0]       exmem_rd;
    logic [4:0]       ifid_rn;
    logic [4:0]       ifid_rm;
    logic [4:0]       ifid_rt;
    logic             ifid_uses_rn;
    logic             ifid_uses_rm;
    logic             cbz;
    logic             br_taken;
    logic             count_clr;
    logic             pc_write;
    logic             ifid_write;
    logic             idex_bubble;
    logic             ifid_flush;
    logic [CNT_W-1:0] stall_count;
    logic [CNT_W-1:0] flush_count;
    logic             hold_state;
    modport master (
        output idex_mem_read, idex_reg_write, idex_rd, exmem_mem_read, exmem_rd,
               ifid_rn, ifid_rm, ifid_rt, ifid_uses_rn, ifid_uses_rm, cbz, br_taken, count_clr,
        input  pc_write, ifid_write, idex_bubble, ifid_flush, stall_count, flush_count, hold_state
    );
    modport slave (
        input  idex_mem_read, idex_reg_write, idex_rd, exmem_mem_read, exmem_rd,
               ifid_rn, ifid_rm, ifid_rt, ifid_uses_rn, ifid_uses_rm, cbz, br_taken, count_clr,
        output pc_write, ifid_write, idex_bubble, ifid_flush, stall_count, flush_count, hold_state
    );
endinterface

// File: rtl/hazard_stall_unit.sv
// hazard_stall_unit: load-use / CBZ stall and taken-branch flush control with perf counters
module hazard_stall_unit #(parameter int CNT_W = 16) (
    input logic clk,
    input logic reset,
    hazard_stall_unit_if.slave hz
);
    typedef enum logic {RUN, HOLD} state_t;
    state_t state, state_nx;
    logic rt_live, load_use, need1, need2, stall;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;
    // dependencies of the ID instruction on producers in EX/MEM; X31 never creates one
    always_comb begin
        rt_live = hz.cbz && hz.ifid_rt != 5'd31;
        load_use = hz.idex_mem_read && hz.idex_rd != 5'd31 &&
                   ((hz.ifid_uses_rn && hz.idex_rd == hz.ifid_rn) ||
                    (hz.ifid_uses_rm && hz.idex_rd == hz.ifid_rm) ||
                    (hz.cbz && hz.idex_rd == hz.ifid_rt));
        need2 = rt_live && hz.idex_mem_read && hz.idex_rd == hz.ifid_rt;
        need1 = load_use || (rt_live &&
                ((hz.idex_reg_write && !hz.idex_mem_read && hz.idex_rd == hz.ifid_rt) ||
                 (hz.exmem_mem_read && hz.exmem_rd == hz.ifid_rt)));
    end
    // state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= RUN;
        else state <= state_nx;
    end
    // a load feeding CBZ needs a second stall cycle, taken from HOLD
    always_comb state_nx = (state == RUN && need2) ? HOLD : RUN;
    // stall/flush controls; reset forces the free-running defaults
    always_comb begin
        stall = !reset && (state == HOLD || need1 || need2);
        hz.pc_write = !stall;
        hz.ifid_write = !stall;
        hz.idex_bubble = stall;
        hz.ifid_flush = !reset && hz.br_taken && !stall;
        hz.hold_state = state == HOLD;
    end
    // saturating stall/flush counters, clear wins over increment
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            stall_cnt <= hz.count_clr ? '0 : (stall && stall_cnt != '1) ? stall_cnt + 1'b1 : stall_cnt;
            flush_cnt <= hz.count_clr ? '0 : (hz.ifid_flush && flush_cnt != '1) ? flush_cnt + 1'b1 : flush_cnt;
        end
    end
    assign hz.stall_count = stall_cnt;
    assign hz.flush_count = flush_cnt;
endmodule

// File: tb/tb_hazard_stall_unit.sv
// tb_hazard_stall_unit: directed vector table plus multi-cycle sequences for hazard_stall_unit
module tb_hazard_stall_unit;
    logic clk = 0;
    logic reset = 1;
    int checks = 0;
    int failures = 0;
    int exp_sc = 0;
    int exp_fc = 0;
    hazard_stall_unit_if hz();
    hazard_stall_unit dut (.clk(clk), .reset(reset), .hz(hz));
    always #5 clk = ~clk;
    typedef struct {
        string name;
        logic mr, rw;
        logic [4:0] rd;
        logic emr;
        logic [4:0] erd, rn, rm, rt;
        logic urn, urm, cbz, br, st, fl;
    } vec_t;
    vec_t tbl[13];
    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask
    task automatic chk_out(input string name, input bit st, input bit fl, input bit hold);
        chk({name, ".pc_write"}, int'(hz.pc_write), int'(!st));
        chk({name, ".ifid_write"}, int'(hz.ifid_write), int'(!st));
        chk({name, ".idex_bubble"}, int'(hz.idex_bubble), int'(st));
        chk({name, ".ifid_flush"}, int'(hz.ifid_flush), int'(fl));
        chk({name, ".hold_state"}, int'(hz.hold_state), int'(hold));
    endtask
    task automatic chk_cnt(input string name);
        chk({name, ".stall_count"}, int'(hz.stall_count), exp_sc);
        chk({name, ".flush_count"}, int'(hz.flush_count), exp_fc);
    endtask
    task automatic drive(input vec_t v);
        hz.idex_mem_read = v.mr;
        hz.idex_reg_write = v.rw;
        hz.idex_rd = v.rd;
        hz.exmem_mem_read = v.emr;
        hz.exmem_rd = v.erd;
        hz.ifid_rn = v.rn;
        hz.ifid_rm = v.rm;
        hz.ifid_rt = v.rt;
        hz.ifid_uses_rn = v.urn;
        hz.ifid_uses_rm = v.urm;
        hz.cbz = v.cbz;
        hz.br_taken = v.br;
    endtask
    vec_t idle_v, lu_v, cbzld_v, br_v;
    initial begin
        //              name          mr rw rd  emr erd rn  rm  rt urn urm cbz br st fl
        tbl[0]  = '{"idle",          0, 0, 0,  0,  0,  0,  0,  0, 0,  0,  0,  0, 0, 0};
        tbl[1]  = '{"lu_rn",         1, 1, 2,  0,  0,  2,  9,  0, 1,  1,  0,  0, 1, 0};
        tbl[2]  = '{"xzr",           1, 1, 31, 0,  0,  31, 0,  0, 1,  0,  0,  0, 0, 0};
        tbl[3]  = '{"lu_rm",         1, 1, 4,  0,  0,  1,  4,  0, 1,  1,  0,  0, 1, 0};
        tbl[4]  = '{"rm_unused",     1, 1, 4,  0,  0,  1,  4,  0, 1,  0,  0,  0, 0, 0};
        tbl[5]  = '{"alu_fwd",       0, 1, 3,  0,  0,  3,  0,  0, 1,  0,  0,  0, 0, 0};
        tbl[6]  = '{"cbz_alu",       0, 1, 7,  0,  0,  0,  0,  7, 0,  0,  1,  0, 1, 0};
        tbl[7]  = '{"cbz_exmem_ld",  0, 0, 0,  1,  7,  0,  0,  7, 0,  0,  1,  0, 1, 0};
        tbl[8]  = '{"cbz_xzr",       0, 0, 0,  1,  31, 0,  0,  31, 0, 0,  1,  0, 0, 0};
        tbl[9]  = '{"br_flush",      0, 0, 0,  0,  0,  0,  0,  0, 0,  0,  0,  1, 0, 1};
        tbl[10] = '{"br_need1",      1, 1, 2,  0,  0,  2,  0,  0, 1,  0,  0,  1, 1, 0};
        tbl[11] = '{"not_cbz",       0, 1, 7,  0,  0,  0,  0,  7, 0,  0,  0,  0, 0, 0};
        tbl[12] = '{"exmem_ld_rn",   0, 0, 0,  1,  5,  5,  0,  0, 1,  0,  0,  0, 0, 0};
        idle_v = tbl[0];
        lu_v = tbl[1];
        cbzld_v = '{"cbz_ld", 1, 1, 5, 0, 0, 0, 0, 5, 0, 0, 1, 0, 1, 0};
        br_v = tbl[9];
        hz.count_clr = 0;
        drive(idle_v);
        #2;
        chk_out("rst", 0, 0, 0);
        chk_cnt("rst");
        drive(lu_v);
        hz.br_taken = 1;
        #1;
        chk_out("rst_forced", 0, 0, 0);
        drive(idle_v);
        @(negedge clk);
        reset = 0;
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            drive(tbl[i]);
            #1;
            chk_out(tbl[i].name, tbl[i].st, tbl[i].fl, 0);
            exp_sc += int'(tbl[i].st);
            exp_fc += int'(tbl[i].fl);
        end
        @(negedge clk);
        drive(idle_v);
        #1;
        chk_cnt("table");
        // CBZ after load: two stalls, branch ignored while held, then flush
        @(negedge clk);
        drive(cbzld_v);
        #1;
        chk_out("cbz_ld_1", 1, 0, 0);
        @(negedge clk);
        drive(br_v);
        #1;
        chk_out("cbz_ld_2", 1, 0, 1);
        @(negedge clk);
        #1;
        chk_out("cbz_ld_3", 0, 1, 0);
        exp_sc += 2;
        exp_fc += 1;
        @(negedge clk);
        drive(idle_v);
        #1;
        chk_cnt("cbz_ld");
        // new load-use right as HOLD ends stalls again at once
        @(negedge clk);
        drive(cbzld_v);
        @(negedge clk);
        drive(lu_v);
        #1;
        chk_out("hold_then_lu", 1, 0, 1);
        @(negedge clk);
        #1;
        chk_out("post_hold_lu", 1, 0, 0);
        exp_sc += 3;
        @(negedge clk);
        drive(idle_v);
        #1;
        chk_cnt("post_hold");
        // clear together with a stall event
        @(negedge clk);
        drive(lu_v);
        hz.count_clr = 1;
        @(negedge clk);
        hz.count_clr = 0;
        drive(idle_v);
        exp_sc = 0;
        exp_fc = 0;
        #1;
        chk_cnt("clr");
        // async reset mid-HOLD
        @(negedge clk);
        drive(cbzld_v);
        @(negedge clk);
        drive(br_v);
        #1;
        chk("pre_rst.hold_state", int'(hz.hold_state), 1);
        #1;
        reset = 1;
        #1;
        exp_sc = 0;
        exp_fc = 0;
        chk_out("rst_hold", 0, 0, 0);
        chk_cnt("rst_hold");
        @(negedge clk);
        reset = 0;
        #1;
        chk_out("post_rst", 0, 1, 0);
        // saturation of the stall counter
        @(negedge clk);
        drive(lu_v);
        hz.count_clr = 1;
        @(negedge clk);
        hz.count_clr = 0;
        repeat (65535) @(posedge clk);
        @(negedge clk);
        #1;
        exp_sc = 65535;
        exp_fc = 0;
        chk_out("sat_a", 1, 0, 0);
        chk_cnt("sat_a");
        @(negedge clk);
        #1;
        chk_cnt("sat_b");
        drive(idle_v);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/hazard_stall_unit.md
# hazard_stall_unit

Pipeline hazard controller for the 5-stage LEGv8 core. It covers the hazards that operand forwarding cannot resolve. It detects load-use and register-compare-branch (CBZ) dependencies on the instruction in IF/ID and stalls the front end for 1 or 2 cycles. It also flushes IF/ID on a taken branch. Forwarding supplies operands once a result exists; this block holds the pipeline until that is true. It sits in ID, beside the register file, and drives the PC, IF/ID and ID/EX write controls. Saturating stall and flush counters support performance debug.

## Interface
- CNT_W, 16, width of each saturating performance counter
- clk  in  1  pipeline clock, rising edge
- reset  in  1  asynchronous, active-high
- IDEXMemRead  in  1  instruction in EX is a load
- IDEXRegWrite  in  1  instruction in EX writes a register
- IDEXRd  in  5  destination of instruction in EX
- EXMEMMemRead  in  1  instruction in MEM is a load
- EXMEMRd  in  5  destination of instruction in MEM
- IFIDRn, IFIDRm, IFIDRt  in  5 each  source fields of instruction in ID
- IFIDUsesRn, IFIDUsesRm  in  1 each  instruction in ID reads Rn / Rm
- CBZ  in  1  instruction in ID is CBZ and compares IFIDRt in ID
- BrTaken  in  1  ID-stage branch resolution: branch taken (B, BL, BR, taken CBZ/B.cond)
- CountClr  in  1  synchronous clear of both counters
- PCWrite  out  1  PC may update
- IFIDWrite  out  1  IF/ID register may load
- IDEXBubble  out  1  load a NOP (all control bits 0) into ID/EX
- IFIDFlush  out  1  replace next IF/ID contents with NOP
- StallCount  out  CNT_W  stall cycles, saturating
- FlushCount  out  CNT_W  flushes, saturating
- HoldState  out  1  1 while in HOLD state (debug)

## Operation
- X31 (5'b11111) is XZR. It never creates a dependency.
- The load-use hazard is asserted when all of the following hold:
  - IDEXMemRead is 1 and IDEXRd != 31;
  - IDEXRd equals a register the ID instruction reads, i.e. (IFIDUsesRn & IDEXRd==IFIDRn) | (IFIDUsesRm & IDEXRd==IFIDRm) | (CBZ & IDEXRd==IFIDRt).
- CBZ hazards, evaluated only when CBZ=1 and IFIDRt != 31:
  - need2 when IDEXMemRead & IDEXRd==IFIDRt. A load in EX must pass through MEM before its data reaches ID.
  - need1 when (IDEXRegWrite & !IDEXMemRead & IDEXRd==IFIDRt) or (EXMEMMemRead & EXMEMRd==IFIDRt).
  - A non-CBZ load-use hazard is also need1.
- FSM has two states.
  - RUN: stall = need1 | need2. If need2, go to HOLD. Otherwise stay in RUN.
  - HOLD: stall = 1 regardless of inputs. Return to RUN unconditionally.
- While stall=1: PCWrite=0, IFIDWrite=0, IDEXBubble=1.
- While stall=0: PCWrite=1, IFIDWrite=1, IDEXBubble=0.
- IFIDFlush = BrTaken & !stall. BrTaken is ignored while stalled because branch operands are not yet valid; the branch re-resolves after the stall.
- StallCount increments on every stall cycle. FlushCount increments on every cycle with IFIDFlush=1. Both saturate at 2^CNT_W-1.
- CountClr has priority over increment: both counters read 0 on the next cycle.

## Timing
- Reset, asynchronous, any time including while in HOLD:
  - state goes to RUN; counters go to 0; HoldState=0;
  - while reset=1, outputs are forced to PCWrite=1, IFIDWrite=1, IDEXBubble=0, IFIDFlush=0.
- In RUN, stall outputs are combinational from the current-cycle inputs, with zero latency.
- In HOLD, stall comes from registered state.
- need2 therefore gives exactly 2 consecutive stall cycles. need1 gives 1 stall cycle; the inputs then change because ID/EX now holds a bubble.
- In HOLD, inputs are don't-care for stall; they are still evaluated for the counters.
- IFIDFlush affects only the next IF/ID load. The PC redirect itself is handled by the PC mux.
- On the edge where the state leaves HOLD, the RUN evaluation uses fresh inputs, so a new need1 is allowed immediately.
- A counter at max plus another event stays at max. CountClr together with an event gives 0.

## Test plan
- Load-use: IDEX LDUR X2 (IDEXMemRead=1, IDEXRd=2), ID ADD reads Rn=2 with UsesRn=1 → stall for 1 cycle: PCWrite=0, IFIDWrite=0, IDEXBubble=1; StallCount 0→1.
- XZR: same as the load-use case but IDEXRd=31 and IFIDRn=31 → no stall; all outputs at RUN defaults.
- CBZ after load: IDEX LDUR X5, ID CBZ with IFIDRt=5 → 2 stall cycles with HoldState=1 on the second; StallCount=2; next cycle PCWrite=1.
- CBZ after ALU: IDEX ADD X7 (IDEXRegWrite=1, IDEXMemRead=0), CBZ with Rt=7 → 1 stall. Also EXMEM load X7 with CBZ Rt=7 → 1 stall.
- Branch flush: BrTaken=1 with no hazard → IFIDFlush=1, FlushCount+1. BrTaken=1 together with need1 → IFIDFlush=0 and stall=1.
- Reset in HOLD: assert reset mid-HOLD → HoldState=0 immediately, counters 0, PCWrite=1. Separately, preload StallCount to 16'hFFFF → remains 16'hFFFF after a further stall.
